uds_seq_ctrl: RTL
=================

// Module: uds_seq_ctrl
// PURPOSE
//  Job sequencer for the up/down-sample engine (UDS). Latches one job config (mode, scale, tile count).
//  Pulls tiles from an upstream valid/ready stream and drives the UDS load/active/idata_valid pattern per tile.
//  Captures each UDS result pulse into a hold register and presents it downstream with valid/ready.
//  Sits between the tile buffer and the UDS instance; one outstanding tile in the UDS at any time.
// PARAMETERS
//  A          64   UDS input elements per tile (8x8); data width A*32, result width 2*(A-8)*32
//  TCNT_W     16   width of tile counter / cfg_num_tiles
//  ACT_LEN    1    cycles uds_active is held high after each load (1..7)
//  WAIT_MAX   15   max cycles in WAIT for uds_odata_valid before timeout abort
// PORTS
//  clk               in   1              clock, all logic on posedge
//  rst_n             in   1              asynchronous active-low reset
//  cfg_start         in   1              start job (accepted only in IDLE)
//  cfg_function_mode in   2              [1]=1 upsample, [1]=0 downsample; [0]=1 avg, 0 max
//  cfg_scale_factor  in   2              downsample: 0=2x2 s2, 1=3x3 s2; 2,3 illegal
//  cfg_num_tiles     in   TCNT_W         tiles in job
//  busy              out  1              job in progress
//  done              out  1              1-cycle pulse, job completed normally
//  err_cfg           out  1              1-cycle pulse, start refused (illegal cfg)
//  err_timeout       out  1              1-cycle pulse, UDS result missing, job aborted
//  in_data           in   A*32           tile from buffer
//  in_valid          in   1              tile valid
//  in_ready          out  1              controller takes tile
//  uds_idata         out  A*32           registered tile to UDS
//  uds_idata_valid   out  1              load strobe to UDS
//  uds_active        out  1              UDS active (compute-in-place) control
//  uds_function_mode out  2              latched job mode, stable for whole job
//  uds_scale_factor  out  2              latched job scale, stable for whole job
//  uds_odata         in   2*(A-8)*32     UDS result
//  uds_odata_valid   in   1              UDS result pulse (cannot be stalled)
//  out_data          out  2*(A-8)*32     held result
//  out_valid         out  1              held result valid
//  out_ready         in   1              downstream accepts
//  out_last          out  1              qualifies out_data: last tile of job
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, hold register empty, counters 0. Reset mid-job aborts silently.
//  FSM: IDLE -> ISSUE -> ACT -> WAIT -> ISSUE|FINISH -> IDLE.
//   IDLE: cfg_start & legal cfg -> latch mode/scale/num_tiles, busy=1; num_tiles==0 -> FINISH.
//    illegal (mode[1]==0 & scale>1) -> err_cfg pulse next cycle, stay IDLE. cfg_start ignored when busy.
//   ISSUE: in_ready = hold empty (or out_valid&out_ready this cycle). On in_valid&in_ready:
//    uds_idata<=in_data, uds_idata_valid<=1 for exactly 1 cycle with uds_active=0; -> ACT.
//   ACT: uds_active=1 for ACT_LEN cycles, uds_idata_valid=0; -> WAIT.
//   WAIT: uds_active=0; uds_odata_valid -> capture into hold (out_valid=1 next cycle), tile_cnt++;
//    tile_cnt==num_tiles -> FINISH else ISSUE. Timer >WAIT_MAX -> err_timeout pulse, drop hold, IDLE.
//   FINISH: wait until hold empty, then done pulse 1 cycle, busy=0, IDLE.
//  uds_odata_valid outside WAIT: ignored (counted as no tile), never overwrites hold.
//  Hold: out_data/out_valid/out_last stable while out_valid&!out_ready; cleared on accept.
//   Issue never starts while hold full, so capture can never collide with a full hold.
//  out_last=1 with the result whose tile_cnt+1==num_tiles.
//  Latency per tile: handshake -> load 1 cyc -> ACT_LEN -> UDS result; throughput 1 tile per
//   (2+ACT_LEN+UDS latency) cycles with out_ready held high.
//  tile_cnt is TCNT_W bits; num_tiles max 2^TCNT_W-1, no wrap.
// STRUCTURE
//  uds_pkg: state enum (IDLE,ISSUE,ACT,WAIT,FINISH), mode bit positions, scale encodings, legal-cfg function.
//  Sub-module uds_out_hold: single-entry result register with valid/ready and last flag.
// TESTING
//  T1 up 2x, num_tiles=3, out_ready=1: 3 loads, each uds_idata_valid 1 cyc then uds_active ACT_LEN cyc; 3 outputs, last on 3rd; done once.
//  T2 down max 2x2, num_tiles=2, out_ready=0 for 20 cyc: in_ready stays 0 after 1st capture; out_data stable; 2nd tile issues after accept.
//  T3 cfg_scale_factor=2 with mode=2'b00: err_cfg pulse, busy stays 0, no uds_idata_valid.
//  T4 num_tiles=0: busy 1 cycle, done pulse, no in_ready.
//  T5 UDS model drops result of tile 2: err_timeout after WAIT_MAX+1 WAIT cycles, IDLE, out_valid=0.
//  T6 rst_n low during ACT: all outputs 0 asynchronously; new job after release runs cleanly.

Source files
------------

// File: rtl/uds_seq_ctrl_pkg.sv
// uds_seq_ctrl_pkg: FSM states, mode/scale encodings and the config legality check for the UDS sequencer
package uds_seq_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, ACT, WAIT, FINISH} state_e;
  localparam int MODE_UP_BIT = 1;
  localparam logic [1:0] SCALE_3X3_S2 = 2'd1;
  function automatic logic cfg_legal(input logic [1:0] mode, input logic [1:0] scale);
    return mode[MODE_UP_BIT] || scale <= SCALE_3X3_S2;
  endfunction
endpackage

// File: rtl/uds_seq_ctrl_if.sv
// uds_seq_ctrl_if: tile stream in, UDS load/result side and result stream out
interface uds_seq_ctrl_if #(parameter int A = 64);
  localparam int DW = A * 32;
  localparam int RW = 2 * (A - 8) * 32;
  logic [DW-1:0] in_data;
  logic in_valid, in_ready;
  logic [DW-1:0] uds_idata;
  logic uds_idata_valid, uds_active;
  logic [1:0] uds_function_mode, uds_scale_factor;
  logic [RW-1:0] uds_odata;
  logic uds_odata_valid;
  logic [RW-1:0] out_data;
  logic out_valid, out_ready, out_last;
  modport master(
    input in_data, in_valid, uds_odata, uds_odata_valid, out_ready,
    output in_ready, uds_idata, uds_idata_valid, uds_active, uds_function_mode, uds_scale_factor,
    output out_data, out_valid, out_last
  );
  modport slave(
    output in_data, in_valid, uds_odata, uds_odata_valid, out_ready,
    input in_ready, uds_idata, uds_idata_valid, uds_active, uds_function_mode, uds_scale_factor,
    input out_data, out_valid, out_last
  );
endinterface

// File: rtl/uds_seq_ctrl_out_hold.sv
// uds_out_hold: single-entry result register with valid/ready and a last-tile flag
module uds_out_hold #(parameter int W = 3584) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         cap,
  input  logic [W-1:0] cap_data,
  input  logic         cap_last,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last
);
  logic [W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, acc;
  always_comb begin
    acc = valid_q && out_ready;
    valid_d = clear ? 1'b0 : cap ? 1'b1 : acc ? 1'b0 : valid_q;
    data_d = clear || (acc && !cap) ? '0 : cap ? cap_data : data_q;
    last_d = clear || (acc && !cap) ? 1'b0 : cap ? cap_last : last_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
    end
  assign out_data = data_q;
  assign out_valid = valid_q;
  assign out_last = last_q;
endmodule

// File: rtl/uds_seq_ctrl.sv
// uds_seq_ctrl: job sequencer feeding one tile at a time into the UDS and holding each result for downstream
module uds_seq_ctrl
  import uds_seq_ctrl_pkg::*;
#(
  parameter int A = 64,
  parameter int TCNT_W = 16,
  parameter int ACT_LEN = 1,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [1:0]        cfg_function_mode,
  input  logic [1:0]        cfg_scale_factor,
  input  logic [TCNT_W-1:0] cfg_num_tiles,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              err_timeout,
  uds_seq_ctrl_if.master    bus
);
  localparam int DW = A * 32;
  localparam int RW = 2 * (A - 8) * 32;
  localparam int TW = $clog2(WAIT_MAX + 1);
  localparam int AW = $clog2(ACT_LEN + 1);
  state_e state_q, state_d;
  logic [1:0] mode_q, mode_d, scale_q, scale_d;
  logic [TCNT_W-1:0] ntiles_q, ntiles_d, tile_cnt_q, tile_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] act_cnt_q, act_cnt_d;
  logic [DW-1:0] idata_q, idata_d;
  logic idv_q, idv_d, active_q, active_d, done_q, done_d, err_cfg_q, err_cfg_d, err_to_q, err_to_d;
  logic in_rdy, cap, clear, last_tile, act_last;
  assign in_rdy = state_q == ISSUE && (!bus.out_valid || bus.out_ready);
  assign last_tile = tile_cnt_q + TCNT_W'(1) == ntiles_q;
  assign act_last = act_cnt_q == AW'(ACT_LEN - 1);
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    scale_d = scale_q;
    ntiles_d = ntiles_q;
    tile_cnt_d = tile_cnt_q;
    timer_d = timer_q;
    act_cnt_d = act_cnt_q;
    idata_d = idata_q;
    idv_d = 1'b0;
    active_d = 1'b0;
    done_d = 1'b0;
    err_cfg_d = 1'b0;
    err_to_d = 1'b0;
    cap = 1'b0;
    clear = 1'b0;
    case (state_q)
      IDLE: if (cfg_start) begin
        if (cfg_legal(cfg_function_mode, cfg_scale_factor)) begin
          mode_d = cfg_function_mode;
          scale_d = cfg_scale_factor;
          ntiles_d = cfg_num_tiles;
          tile_cnt_d = '0;
          state_d = cfg_num_tiles == '0 ? FINISH : ISSUE;
        end else err_cfg_d = 1'b1;
      end
      ISSUE: if (bus.in_valid && in_rdy) begin
        idata_d = bus.in_data;
        idv_d = 1'b1;
        act_cnt_d = '0;
        state_d = ACT;
      end
      // the load cycle (idv_q) precedes the ACT_LEN cycles of uds_active
      ACT: begin
        active_d = idv_q || !act_last;
        act_cnt_d = idv_q ? act_cnt_q : act_cnt_q + AW'(1);
        state_d = !idv_q && act_last ? WAIT : ACT;
        timer_d = '0;
      end
      WAIT: if (bus.uds_odata_valid) begin
        cap = 1'b1;
        tile_cnt_d = tile_cnt_q + TCNT_W'(1);
        state_d = last_tile ? FINISH : ISSUE;
      end else if (timer_q == TW'(WAIT_MAX)) begin
        err_to_d = 1'b1;
        clear = 1'b1;
        state_d = IDLE;
      end else timer_d = timer_q + TW'(1);
      FINISH: if (!bus.out_valid) begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= '0;
      scale_q <= '0;
      ntiles_q <= '0;
      tile_cnt_q <= '0;
      timer_q <= '0;
      act_cnt_q <= '0;
      idata_q <= '0;
      idv_q <= 1'b0;
      active_q <= 1'b0;
      done_q <= 1'b0;
      err_cfg_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      scale_q <= scale_d;
      ntiles_q <= ntiles_d;
      tile_cnt_q <= tile_cnt_d;
      timer_q <= timer_d;
      act_cnt_q <= act_cnt_d;
      idata_q <= idata_d;
      idv_q <= idv_d;
      active_q <= active_d;
      done_q <= done_d;
      err_cfg_q <= err_cfg_d;
      err_to_q <= err_to_d;
    end
  uds_out_hold #(.W(RW)) u_hold (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .cap(cap),
    .cap_data(bus.uds_odata),
    .cap_last(last_tile),
    .out_ready(bus.out_ready),
    .out_data(bus.out_data),
    .out_valid(bus.out_valid),
    .out_last(bus.out_last)
  );
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err_cfg = err_cfg_q;
  assign err_timeout = err_to_q;
  assign bus.in_ready = in_rdy;
  assign bus.uds_idata = idata_q;
  assign bus.uds_idata_valid = idv_q;
  assign bus.uds_active = active_q;
  assign bus.uds_function_mode = mode_q;
  assign bus.uds_scale_factor = scale_q;
endmodule
